// File: rtl/uart_rx_os16_if.sv
// Receive holding-register bus between the UART receiver and its consumer.
// Latency: none; this is wiring only.
// Backpressure: none on the line; rx_ack from the slave releases the held byte.
// Ports (master = receiver side):
//   rx_ack      consumer acknowledge (slave -> master)
//   rx_data     last received byte
//   rx_valid    byte held, not yet acknowledged
//   frame_err   stop bit of the held byte sampled low
//   parity_err  parity mismatch on the held byte
//   overrun     a byte was overwritten before it was acknowledged
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    input  rx_ack,
    output rx_data, rx_valid, frame_err, parity_err, overrun
  );

  modport slave (
    output rx_ack,
    input  rx_data, rx_valid, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_os16.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), optional even parity, 1 stop; 16x oversampled on baud_clk.
// Latency: byte valid on the stop-sample edge, 152 edges after the start edge (8 data bits, 168 with parity).
// Backpressure: none on the line; an unacknowledged byte is overwritten and overrun is flagged.
// Optional feature: define UART_RX_PARITY_EN to add the parity bit and its check.
// Ports:
//   baud_clk  16x bit-rate clock, rising edge
//   reset     asynchronous, active-high
//   rx_in     serial line, idle high, asynchronous to baud_clk
//   rx_bus    holding-register bus (master side): rx_ack in; rx_data, rx_valid, error flags out
//   rx_busy   receiver is somewhere inside a frame
module uart_rx_os16 #(
  parameter int DATA_BITS = 8
) (
  input  logic           baud_clk,
  input  logic           reset,
  input  logic           rx_in,
  uart_rx_os16_if.master rx_bus,
  output logic           rx_busy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [3:0]           cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 armed_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 rx_s;
  logic                 commit;

  assign rx_s   = sync_q[1];
  assign commit = (state_q == STOP) && (cnt_q == 4'd15);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_in};
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic perr_q;
`endif

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      armed_q <= 1'b0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // A low line only starts a frame once the line has been seen high,
          // so a break or stuck-low line cannot retrigger frames.
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= START;
            armed_q <= 1'b0;
          end
        end
        START: begin
          if (cnt_q == 4'd7) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
            end else begin
              // False start: the line is already back high, so stay armed.
              state_q <= IDLE;
              armed_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DATA: begin
          cnt_q <= cnt_q + 4'd1;  // wraps to 0 after the mid-bit sample
          if (cnt_q == 4'd15) begin
            shreg_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            par_q   <= rx_s;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= IDLE;
            // A high stop bit counts as having seen the line high, which lets
            // the next start bit follow immediately at full rate.
            armed_q <= rx_s;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Holding register: a commit always wins over a same-cycle ack.
      if (commit) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
        ferr_q  <= ~rx_s;
        ovr_q   <= ovr_q | (valid_q & ~rx_bus.rx_ack);
`ifdef UART_RX_PARITY_EN
        perr_q  <= (^shreg_q) ^ par_q;
`endif
      end else if (rx_bus.rx_ack && valid_q) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_q  <= 1'b0;
`endif
      end
    end
  end

  assign rx_bus.rx_data   = data_q;
  assign rx_bus.rx_valid  = valid_q;
  assign rx_bus.frame_err = ferr_q;
  assign rx_bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.parity_err = perr_q;
`else
  assign rx_bus.parity_err = 1'b0;
`endif

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: frames, glitch, break, overrun, parity, mid-frame reset.
// Latency: expected rx_valid rise is 3 cycles of synchronizer/IDLE delay plus 152 (168 with parity).
// Backpressure: rx_ack driven from directed stimulus.
module tb_uart_rx_os16;

  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Line change after edge P -> rx_s low seen by IDLE at edge P+3 (edge 0),
  // rx_valid set on edge 0 + 152 (168 with parity).
  localparam int LAT = PB ? 171 : 155;

  logic baud_clk = 1'b0;
  logic reset;
  logic rx_in;
  logic rx_busy;

  uart_rx_os16_if #(.DATA_BITS(DB)) bus ();

  uart_rx_os16 #(.DATA_BITS(DB)) dut (
    .baud_clk (baud_clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_bus   (bus),
    .rx_busy  (rx_busy)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc++;

  int   rise_cyc = -1;
  logic prev_v = 1'b0;
  always @(negedge baud_clk) begin
    if (bus.rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = bus.rx_valid;
  end

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge baud_clk);
      #1;
    end
  endtask

  // Drives one frame, 16 ticks per bit. ack_t: tick index at which rx_ack is
  // raised for one edge (-1 = never). max_t: stop driving early at this tick.
  task automatic send_frame(input logic [8:0] d, input bit stop_b, input bit par_flip,
                            input int ack_t, input int max_t);
    logic [11:0] fb;
    int n;
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < DB; i++) fb[1+i] = d[i];
    if (PB != 0) fb[1+DB] = (^d[DB-1:0]) ^ par_flip;
    fb[1+DB+PB] = stop_b;
    n = 2 + DB + PB;
    start_cyc = cyc;
    for (int t = 0; t < n*16 && t < max_t; t++) begin
      rx_in      = fb[t/16];
      bus.rx_ack = (t == ack_t);
      tick();
    end
    bus.rx_ack = 1'b0;
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    rx_in      = 1'b1;
    bus.rx_ack = 1'b0;
    tick(3);
    chk("rst_data",  32'(bus.rx_data),   32'h0);
    chk("rst_valid", 32'(bus.rx_valid),  32'h0);
    chk("rst_ferr",  32'(bus.frame_err), 32'h0);
    chk("rst_perr",  32'(bus.parity_err),32'h0);
    chk("rst_ovr",   32'(bus.overrun),   32'h0);
    chk("rst_busy",  32'(rx_busy),       32'h0);
    reset = 1'b0;
    tick(20);

    // Basic frame 0xA5.
    send_frame(9'h0A5, 1'b1, 1'b0, -1, 10000);
    chk("a5_data",  32'(bus.rx_data),    32'hA5);
    chk("a5_valid", 32'(bus.rx_valid),   32'h1);
    chk("a5_ferr",  32'(bus.frame_err),  32'h0);
    chk("a5_perr",  32'(bus.parity_err), 32'h0);
    chk("a5_lat",   32'(rise_cyc - start_cyc), 32'(LAT));
    ack();
    chk("a5_ackclr", 32'(bus.rx_valid), 32'h0);
    tick(10);

    // 4-cycle glitch: START aborts at its mid-bit check.
    rx_in = 1'b0;
    tick(4);
    chk("gl_busy", 32'(rx_busy), 32'h1);
    rx_in = 1'b1;
    tick(20);
    chk("gl_idle",  32'(rx_busy),      32'h0);
    chk("gl_valid", 32'(bus.rx_valid), 32'h0);
    send_frame(9'h03C, 1'b1, 1'b0, -1, 10000);
    chk("3c_data",  32'(bus.rx_data),   32'h3C);
    chk("3c_valid", 32'(bus.rx_valid),  32'h1);
    chk("3c_ferr",  32'(bus.frame_err), 32'h0);
    ack();
    tick(10);

    // Framing error followed by a held-low line.
    send_frame(9'h081, 1'b0, 1'b0, -1, 10000);
    tick(40);
    chk("br_data",  32'(bus.rx_data),   32'h81);
    chk("br_valid", 32'(bus.rx_valid),  32'h1);
    chk("br_ferr",  32'(bus.frame_err), 32'h1);
    chk("br_busy",  32'(rx_busy),       32'h0);
    ack();
    chk("br_ferrclr", 32'(bus.frame_err), 32'h0);
    tick(10);
    chk("br_noretrig", 32'(rx_busy), 32'h0);
    rx_in = 1'b1;
    tick(20);
    chk("br_idle",  32'(rx_busy),      32'h0);
    chk("br_novld", 32'(bus.rx_valid), 32'h0);

    // Back-to-back without ack: overrun.
    send_frame(9'h011, 1'b1, 1'b0, -1, 10000);
    send_frame(9'h022, 1'b1, 1'b0, -1, 10000);
    chk("ov_data",  32'(bus.rx_data),   32'h22);
    chk("ov_valid", 32'(bus.rx_valid),  32'h1);
    chk("ov_ovr",   32'(bus.overrun),   32'h1);
    chk("ov_ferr",  32'(bus.frame_err), 32'h0);
    ack();
    chk("ov_vclr", 32'(bus.rx_valid), 32'h0);
    chk("ov_oclr", 32'(bus.overrun),  32'h0);
    tick(10);

    // Back-to-back with ack on the second commit edge: new byte wins.
    send_frame(9'h011, 1'b1, 1'b0, -1, 10000);
    send_frame(9'h022, 1'b1, 1'b0, LAT - 1, 10000);
    chk("ac_data",  32'(bus.rx_data),  32'h22);
    chk("ac_valid", 32'(bus.rx_valid), 32'h1);
    chk("ac_ovr",   32'(bus.overrun),  32'h0);
    ack();
    tick(10);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 1 is correct, 0 is a mismatch.
    send_frame(9'h007, 1'b1, 1'b0, -1, 10000);
    chk("pg_data", 32'(bus.rx_data),    32'h07);
    chk("pg_perr", 32'(bus.parity_err), 32'h0);
    chk("pg_lat",  32'(rise_cyc - start_cyc), 32'd171);
    ack();
    tick(10);
    send_frame(9'h007, 1'b1, 1'b1, -1, 10000);
    chk("pb_data", 32'(bus.rx_data),    32'h07);
    chk("pb_perr", 32'(bus.parity_err), 32'h1);
    ack();
    chk("pb_pclr", 32'(bus.parity_err), 32'h0);
    tick(10);
`endif

    // Reset during data bit 4 with a byte still held.
    send_frame(9'h033, 1'b1, 1'b0, -1, 10000);
    chk("rs_pre", 32'(bus.rx_valid), 32'h1);
    send_frame(9'h05A, 1'b1, 1'b0, -1, 88);
    chk("rs_busy", 32'(rx_busy), 32'h1);
    reset = 1'b1;
    tick(2);
    chk("rs_data",  32'(bus.rx_data),   32'h0);
    chk("rs_valid", 32'(bus.rx_valid),  32'h0);
    chk("rs_ferr",  32'(bus.frame_err), 32'h0);
    chk("rs_ovr",   32'(bus.overrun),   32'h0);
    chk("rs_bsy0",  32'(rx_busy),       32'h0);
    reset = 1'b0;
    rx_in = 1'b1;
    tick(30);
    send_frame(9'h05A, 1'b1, 1'b0, -1, 10000);
    chk("5a_data",  32'(bus.rx_data),   32'h5A);
    chk("5a_valid", 32'(bus.rx_valid),  32'h1);
    chk("5a_ferr",  32'(bus.frame_err), 32'h0);
    chk("5a_lat",   32'(rise_cyc - start_cyc), 32'(LAT));
    ack();
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
